// File: rtl/final_bitstream_packer.sv
// final_bitstream_packer
// Resolves carry propagation on a stream of 16-bit pre-carry words and emits
// a clean byte stream. A pending byte plus a count of trailing 0xFF bytes is
// held back until a later word decides whether a carry ripples through them.
// On a final beat all held state is flushed and the last byte is marked.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   in_valid/ready  input beat handshake (ready only while idle)
//   in_flag         00/11: no words, 01: in_bit_1, 10: in_bit_1 then in_bit_2
//   in_bit_1/2      pre-carry words: [7:0] data byte, [8] carry, rest ignored
//   in_last         flush after this beat's words
//   out_valid/ready output byte handshake
//   out_byte        resolved byte
//   out_last        marks the final byte of the stream
//   out_done        one-cycle pulse when a flush has completed
//   err_carry       sticky: carry with no pending byte
//   err_run         sticky: 0xFF run counter saturated (byte dropped)
//   out_byte_count  (only with FINAL_BITSTREAM_BYTE_COUNT_EN) bytes handed off
//
// Build option: define FINAL_BITSTREAM_BYTE_COUNT_EN to add out_byte_count.
module final_bitstream_packer #(
    parameter int unsigned OUTPUT_BITSTREAM_WIDTH = 16,
    parameter int unsigned RUN_WIDTH              = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [1:0]                        in_flag,
    input  logic [OUTPUT_BITSTREAM_WIDTH-1:0] in_bit_1,
    input  logic [OUTPUT_BITSTREAM_WIDTH-1:0] in_bit_2,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [7:0]                        out_byte,
    output logic                              out_last,
    output logic                              out_done,
    output logic                              err_carry,
    output logic                              err_run
`ifdef FINAL_BITSTREAM_BYTE_COUNT_EN
    ,
    output logic [31:0]                       out_byte_count
`endif
);

    localparam logic [RUN_WIDTH-1:0] RUN_MAX = '1;

    typedef enum logic [2:0] {
        S_ACCEPT,
        S_PROC,
        S_EMIT_PEND,
        S_EMIT_RUN,
        S_FLUSH_PEND,
        S_FLUSH_RUN,
        S_DONE
    } state_t;

    state_t                 state, state_d;
    logic [8:0]             word1, word1_d, word2, word2_d;
    logic [1:0]             nwords, nwords_d;
    logic                   widx, widx_d;
    logic                   last_q, last_d;
    logic                   have_pend, have_pend_d;
    logic [7:0]             pend_byte, pend_byte_d;
    logic [RUN_WIDTH-1:0]   run, run_d;
    logic [RUN_WIDTH-1:0]   ecnt, ecnt_d;
    logic [7:0]             rval, rval_d;
    logic                   in_ready_d, out_valid_d, out_last_d, out_done_d;
    logic [7:0]             out_byte_d;
    logic                   err_carry_d, err_run_d;
    logic [8:0]             word_c;
    logic                   more_c;
    logic                   hs_c;
    logic                   unused_hi;

    // Upper word bits carry no information for this block.
    assign unused_hi = ^{in_bit_1[OUTPUT_BITSTREAM_WIDTH-1:9], in_bit_2[OUTPUT_BITSTREAM_WIDTH-1:9]};

    assign word_c = widx ? word2 : word1;
    assign more_c = !widx && (nwords == 2'd2);
    assign hs_c   = out_valid && out_ready;

    // Where to go once the current word's emission (if any) is finished.
    function automatic state_t advance(input logic more, input logic last, input logic have);
        if (more)      return S_PROC;
        else if (last) return have ? S_FLUSH_PEND : S_DONE;
        else           return S_ACCEPT;
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        word1_d     = word1;
        word2_d     = word2;
        nwords_d    = nwords;
        widx_d      = widx;
        last_d      = last_q;
        have_pend_d = have_pend;
        pend_byte_d = pend_byte;
        run_d       = run;
        ecnt_d      = ecnt;
        rval_d      = rval;
        out_valid_d = out_valid;
        out_byte_d  = out_byte;
        out_last_d  = out_last;
        err_carry_d = err_carry;
        err_run_d   = err_run;

        case (state)
            S_ACCEPT: begin
                if (in_valid) begin
                    word1_d = in_bit_1[8:0];
                    word2_d = in_bit_2[8:0];
                    case (in_flag)
                        2'b01:   nwords_d = 2'd1;
                        2'b10:   nwords_d = 2'd2;
                        default: nwords_d = 2'd0;
                    endcase
                    last_d  = in_last;
                    widx_d  = 1'b0;
                    state_d = S_PROC;
                end
            end

            S_PROC: begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                if (nwords != 2'd0) begin
                    if (word_c[8]) begin
                        // Carry ripples into pending byte; held 0xFF run wraps to 0x00.
                        if (have_pend) begin
                            out_valid_d = 1'b1;
                            out_byte_d  = pend_byte + 8'd1;
                            ecnt_d      = run;
                            rval_d      = 8'h00;
                        end else begin
                            err_carry_d = 1'b1;
                        end
                        pend_byte_d = word_c[7:0];
                        have_pend_d = 1'b1;
                        run_d       = '0;
                    end else if (word_c[7:0] == 8'hFF) begin
                        // 0xFF may still be hit by a later carry: hold it as run length.
                        if (have_pend) begin
                            if (run == RUN_MAX) err_run_d = 1'b1;
                            else                run_d     = run + RUN_WIDTH'(1);
                        end else begin
                            pend_byte_d = 8'hFF;
                            have_pend_d = 1'b1;
                        end
                    end else begin
                        // Non-0xFF byte absorbs any future carry: release held bytes.
                        if (have_pend) begin
                            out_valid_d = 1'b1;
                            out_byte_d  = pend_byte;
                            ecnt_d      = run;
                            rval_d      = 8'hFF;
                        end
                        pend_byte_d = word_c[7:0];
                        have_pend_d = 1'b1;
                        run_d       = '0;
                    end
                end
                if (out_valid_d) state_d = S_EMIT_PEND;
                else             state_d = advance(more_c, last_q, have_pend_d);
            end

            S_EMIT_PEND: begin
                if (hs_c) begin
                    if (ecnt != '0) begin
                        out_byte_d = rval;
                        state_d    = S_EMIT_RUN;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = advance(more_c, last_q, have_pend);
                    end
                end
            end

            S_EMIT_RUN: begin
                if (hs_c) begin
                    ecnt_d = ecnt - RUN_WIDTH'(1);
                    if (ecnt == RUN_WIDTH'(1)) begin
                        out_valid_d = 1'b0;
                        state_d     = advance(more_c, last_q, have_pend);
                    end
                end
            end

            S_FLUSH_PEND: begin
                if (hs_c) begin
                    if (run != '0) begin
                        out_byte_d = 8'hFF;
                        out_last_d = (run == RUN_WIDTH'(1));
                        state_d    = S_FLUSH_RUN;
                    end else begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = S_DONE;
                    end
                end
            end

            S_FLUSH_RUN: begin
                if (hs_c) begin
                    run_d = run - RUN_WIDTH'(1);
                    if (run == RUN_WIDTH'(1)) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = S_DONE;
                    end else begin
                        out_last_d = (run_d == RUN_WIDTH'(1));
                    end
                end
            end

            S_DONE: begin
                have_pend_d = 1'b0;
                pend_byte_d = 8'h00;
                run_d       = '0;
                ecnt_d      = '0;
                nwords_d    = 2'd0;
                widx_d      = 1'b0;
                last_d      = 1'b0;
                state_d     = S_ACCEPT;
            end

            default: state_d = S_ACCEPT;
        endcase

        // Entering the flush presents the pending byte immediately.
        if (state_d == S_FLUSH_PEND && state != S_FLUSH_PEND) begin
            out_valid_d = 1'b1;
            out_byte_d  = pend_byte_d;
            out_last_d  = (run_d == '0);
        end
        // Moving on to the second word of a beat.
        if (state_d == S_PROC && state != S_ACCEPT) widx_d = 1'b1;

        in_ready_d = (state_d == S_ACCEPT);
        out_done_d = (state_d == S_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_ACCEPT;
            word1     <= '0;
            word2     <= '0;
            nwords    <= 2'd0;
            widx      <= 1'b0;
            last_q    <= 1'b0;
            have_pend <= 1'b0;
            pend_byte <= 8'h00;
            run       <= '0;
            ecnt      <= '0;
            rval      <= 8'h00;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_byte  <= 8'h00;
            out_last  <= 1'b0;
            out_done  <= 1'b0;
            err_carry <= 1'b0;
            err_run   <= 1'b0;
        end else begin
            state     <= state_d;
            word1     <= word1_d;
            word2     <= word2_d;
            nwords    <= nwords_d;
            widx      <= widx_d;
            last_q    <= last_d;
            have_pend <= have_pend_d;
            pend_byte <= pend_byte_d;
            run       <= run_d;
            ecnt      <= ecnt_d;
            rval      <= rval_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_byte  <= out_byte_d;
            out_last  <= out_last_d;
            out_done  <= out_done_d;
            err_carry <= err_carry_d;
            err_run   <= err_run_d;
        end
    end

`ifdef FINAL_BITSTREAM_BYTE_COUNT_EN
    // Running count of bytes handed downstream; survives DONE, wraps at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                       out_byte_count <= 32'd0;
        else if (out_valid && out_ready) out_byte_count <= out_byte_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_final_bitstream_packer.sv
// Directed bench for final_bitstream_packer (RUN_WIDTH=2 so saturation is reachable).
// Bytes are collected as {last, byte} on every handshake and compared to
// hand-computed streams; stall stability and out_done width are watched continuously.
module tb_final_bitstream_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_flag;
    logic [15:0] in_bit_1;
    logic [15:0] in_bit_2;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        out_done;
    logic        err_carry;
    logic        err_run;
`ifdef FINAL_BITSTREAM_BYTE_COUNT_EN
    logic [31:0] out_byte_count;
`endif

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [8:0] got[$];
    logic [8:0] exp_q[$];
    logic toggle = 1'b0;

    always #5 clk = ~clk;

    final_bitstream_packer #(
        .OUTPUT_BITSTREAM_WIDTH(16),
        .RUN_WIDTH(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_flag(in_flag),
        .in_bit_1(in_bit_1),
        .in_bit_2(in_bit_2),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_byte(out_byte),
        .out_last(out_last),
        .out_done(out_done),
        .err_carry(err_carry),
        .err_run(err_run)
`ifdef FINAL_BITSTREAM_BYTE_COUNT_EN
        ,
        .out_byte_count(out_byte_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Handshake monitor, sampled on the falling edge.
    logic       prev_stall = 1'b0;
    logic       prev_done  = 1'b0;
    logic [7:0] prev_byte  = 8'h00;
    logic       prev_last  = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_byte", 32'(out_byte), 32'(prev_byte));
                chk("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid) chk("in_ready_low_while_emitting", 32'(in_ready), 0);
            if (prev_done) chk("done_one_cycle", 32'(out_done), 0);
            if (out_valid && out_ready) got.push_back({out_last, out_byte});
            if (out_done && !prev_done) done_cnt++;
            prev_done  = out_done;
            prev_stall = out_valid && !out_ready;
            prev_byte  = out_byte;
            prev_last  = out_last;
        end
    end

    // Downstream ready: constant 1, or alternating every cycle when toggle is set.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (toggle) out_ready = ~out_ready;
            else        out_ready = 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [1:0] f, input logic [15:0] b1, input logic [15:0] b2,
                             input logic l);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("beat_accepted", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_flag  = f;
        in_bit_1 = b1;
        in_bit_2 = b2;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_flag  = 2'b00;
        in_bit_1 = 16'h0000;
        in_bit_2 = 16'h0000;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt != d0), 1);
        repeat (3) @(negedge clk);
        chk({tag, "_done_once"}, 32'(done_cnt - d0), 1);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    endtask

    initial begin
        int d0;
        int n;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_flag  = 2'b00;
        in_bit_1 = 16'h0000;
        in_bit_2 = 16'h0000;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_byte", 32'(out_byte), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_out_done", 32'(out_done), 0);
        chk("rst_err_carry", 32'(err_carry), 0);
        chk("rst_err_run", 32'(err_run), 0);
        reset = 1'b0;

        // Two plain bytes, last beat.
        got.delete(); d0 = done_cnt;
        send_beat(2'b10, 16'h0012, 16'h0034, 1'b1);
        wait_done("t1", d0);
        exp_q = '{9'h012, 9'h134};
        check_stream("t1");

        // Carry through a two-byte 0xFF run.
        got.delete(); d0 = done_cnt;
        send_beat(2'b10, 16'h0040, 16'h00FF, 1'b0);
        send_beat(2'b10, 16'h00FF, 16'h0105, 1'b1);
        wait_done("t2", d0);
        exp_q = '{9'h041, 9'h000, 9'h000, 9'h105};
        check_stream("t2");

        // Run released without carry.
        got.delete(); d0 = done_cnt;
        send_beat(2'b10, 16'h0040, 16'h00FF, 1'b0);
        send_beat(2'b01, 16'h0007, 16'h0000, 1'b1);
        wait_done("t3a", d0);
        exp_q = '{9'h040, 9'h0FF, 9'h107};
        check_stream("t3a");

        // Carry wraps a pending 0xFF to 0x00; ignored upper bits set.
        got.delete(); d0 = done_cnt;
        send_beat(2'b10, 16'hFE00 | 16'h00FF, 16'h0101, 1'b1);
        wait_done("t3b", d0);
        exp_q = '{9'h000, 9'h101};
        check_stream("t3b");

        // Same as the run-carry case with out_ready alternating.
        toggle = 1'b1;
        got.delete(); d0 = done_cnt;
        send_beat(2'b10, 16'h0040, 16'h00FF, 1'b0);
        send_beat(2'b10, 16'h00FF, 16'h0105, 1'b1);
        wait_done("t4", d0);
        exp_q = '{9'h041, 9'h000, 9'h000, 9'h105};
        check_stream("t4");
        toggle = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_err_carry", 32'(err_carry), 0);
        chk("t4_err_run", 32'(err_run), 0);

        // Run saturation at 3: fourth 0xFF is dropped.
        got.delete(); d0 = done_cnt;
        send_beat(2'b10, 16'h0010, 16'h00FF, 1'b0);
        send_beat(2'b10, 16'h00FF, 16'h00FF, 1'b0);
        send_beat(2'b01, 16'h00FF, 16'h0000, 1'b1);
        wait_done("t5", d0);
        exp_q = '{9'h010, 9'h0FF, 9'h0FF, 9'h1FF};
        check_stream("t5");
        chk("t5_err_run", 32'(err_run), 1);
        chk("t5_err_carry", 32'(err_carry), 0);

        // flag=11 carries no words; empty flush emits nothing but still pulses done.
        got.delete(); d0 = done_cnt;
        send_beat(2'b11, 16'h0077, 16'h0088, 1'b0);
        send_beat(2'b00, 16'h0000, 16'h0000, 1'b1);
        wait_done("tflush", d0);
        exp_q = {};
        check_stream("tflush");

        // Carry with nothing pending.
        got.delete(); d0 = done_cnt;
        send_beat(2'b01, 16'h0120, 16'h0000, 1'b1);
        wait_done("t6a", d0);
        exp_q = '{9'h120};
        check_stream("t6a");
        chk("t6a_err_carry", 32'(err_carry), 1);
        chk("t6a_err_run_sticky", 32'(err_run), 1);

        // Reset while the 0x00 run is being emitted.
        got.delete();
        send_beat(2'b10, 16'h0040, 16'h00FF, 1'b0);
        send_beat(2'b10, 16'h00FF, 16'h0105, 1'b1);
        n = 0;
        while (!(out_valid && out_byte == 8'h41) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t6b_saw_41", 32'(out_byte), 32'h41);
        @(posedge clk);
        #1;
        chk("t6b_run_valid", 32'(out_valid), 1);
        chk("t6b_run_byte", 32'(out_byte), 0);
        reset = 1'b1;
        #1;
        chk("t6b_rst_out_valid", 32'(out_valid), 0);
        chk("t6b_rst_in_ready", 32'(in_ready), 1);
        chk("t6b_rst_err_carry", 32'(err_carry), 0);
        chk("t6b_rst_err_run", 32'(err_run), 0);
        chk("t6b_rst_out_last", 32'(out_last), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Fresh stream after reset.
        got.delete(); d0 = done_cnt;
        send_beat(2'b10, 16'h0012, 16'h0034, 1'b1);
        wait_done("t6c", d0);
        exp_q = '{9'h012, 9'h134};
        check_stream("t6c");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/final_bitstream_packer.md
Name: final_bitstream_packer

Overview:
- Sits directly downstream of the final-bits generator and the stage-4 bitstream outputs.
- Consumes 16-bit pre-carry words: bits[7:0] hold a data byte; bit 8 is a carry into previously produced bytes.
- Resolves carry propagation across runs of 0xFF bytes and emits a clean byte stream over a valid/ready handshake.
- On the final flush it drains all held state and marks the last byte.

Parameters:
- OUTPUT_BITSTREAM_WIDTH, 16, width of each input pre-carry word.
- RUN_WIDTH, 8, width of the pending 0xFF run counter; max run = 2^RUN_WIDTH-1.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous reset, active-high
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat
- in_flag  input  2  00: no words; 01: in_bit_1 only; 10: in_bit_1 then in_bit_2; 11: treated as 00
- in_bit_1  input  OUTPUT_BITSTREAM_WIDTH  first pre-carry word
- in_bit_2  input  OUTPUT_BITSTREAM_WIDTH  second pre-carry word
- in_last  input  1  final beat; flush after this beat's words
- out_valid  output  1  out_byte valid
- out_ready  input  1  downstream accepts byte
- out_byte  output  8  resolved byte
- out_last  output  1  qualifies the final byte of the stream
- out_done  output  1  one-cycle pulse when flush is complete
- err_carry  output  1  sticky: carry arrived with nothing pending
- err_run  output  1  sticky: 0xFF run counter saturated

Behaviour:
- Reset values: all outputs 0 except in_ready=1. Internal state: have_pend=0, pend_byte=0, run=0, FSM=ACCEPT.
- A beat transfers when in_valid & in_ready. Both words and in_last are latched. in_ready is high only in ACCEPT.
- Words are processed in order (bit_1, then bit_2). Each word is processed in one PROC cycle. Per word: c = w[8], b = w[7:0]; w[15:9] is ignored.
  - c=1, have_pend=1: queue pend_byte+1 (mod 256), then run bytes of 0x00. Then pend=b, run=0.
  - c=1, have_pend=0: set err_carry. Then pend=b, have_pend=1, run=0.
  - c=0, b=0xFF, have_pend=1: run++. If run is already at its maximum, set err_run and drop the byte.
  - c=0, b=0xFF, have_pend=0: pend=0xFF, have_pend=1.
  - c=0, b!=0xFF: queue pend_byte (if have_pend), then run bytes of 0xFF. Then pend=b, have_pend=1, run=0.
- FSM states: ACCEPT → PROC → EMIT_PEND → EMIT_RUN → (next word: PROC | last: FLUSH_PEND → FLUSH_RUN → DONE | else ACCEPT).
  - EMIT states are skipped when there is nothing to emit.
- FLUSH: emit pend_byte (if have_pend), then run bytes of 0xFF. out_last is asserted on the final emitted byte.
- DONE: pulse out_done for one cycle, clear all state, return to ACCEPT.
  - If flush has nothing to emit, no byte is produced, out_last never asserts, and out_done still pulses.
- Output is one byte per cycle while out_ready=1.
  - out_byte and out_last are held stable while out_valid & !out_ready.
  - A run counter decrements only on a handshake.
- Latency: the first byte from a beat appears no earlier than 2 cycles after acceptance.
- in_flag=00 with in_last=1 triggers a flush only.
- Reset asserted mid-operation immediately returns all state and outputs to reset values. A partially emitted run is discarded.
- Error flags clear only on reset.

Optional Feature:
- FINAL_BITSTREAM_BYTE_COUNT_EN defined: adds output out_byte_count[31:0].
  - The counter increments on every out_valid & out_ready and wraps at 2^32.
  - It clears on reset but not on DONE.
- Macro undefined: the port is absent and no counter logic is generated.

Test Plan:
1. Beat flag=10, bit_1=0x0012, bit_2=0x0034, last=1 → bytes 0x12, 0x34; out_last on 0x34; out_done pulses once.
2. Beats 0x0040, 0x00FF, 0x00FF, then 0x0105 with last → bytes 0x41, 0x00, 0x00, 0x05 (out_last on 0x05).
3. Beats 0x0040, 0x00FF, 0x0007, last → 0x40, 0xFF, 0x07. Carry wrap: 0x00FF followed by 0x0101 with last → 0x00, 0x01.
4. out_ready toggling 1/0 every cycle during test 2 → identical byte sequence; out_byte stable while stalled; in_ready=0 until emission ends.
5. RUN_WIDTH=2: pending 0x10 followed by four 0x00FF words, then last → err_run=1; bytes 0x10, 0xFF, 0xFF, 0xFF.
6. First word 0x0120 → err_carry=1. Then assert reset during EMIT_RUN of test 2 → out_valid=0, in_ready=1, errors cleared next cycle; a fresh test 1 passes.
